branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised successor to the branch-address calculator: predicts the next fetch PC one branch ahead, instead of only resolving it in execute.
- Direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating direction counters.
- Fetch looks it up combinationally every cycle.
- Execute trains it with the resolved outcome from the branch-address calculator, and it flags mispredicts for the pipeline flush logic.

Parameters:
- WordSize, 32, width of PC and target addresses.
- Entries, 16, number of BTB entries; power of two, minimum 2.
- InstBytes, 4, fall-through PC increment; power of two.

Ports:
- clk  input  1  system clock, rising-edge.
- rstn  input  1  asynchronous active-low reset.
- fetch_pc  input  WordSize  PC being fetched this cycle.
- pred_taken  output  1  predicted taken for fetch_pc.
- pred_target  output  WordSize  stored target, or 0 on miss.
- pred_npc  output  WordSize  predicted next fetch PC.
- upd_valid  input  1  resolved control-flow instruction present this cycle.
- upd_pc  input  WordSize  PC of the resolved instruction.
- upd_taken  input  1  actual outcome (branch_taken from execute).
- upd_target  input  WordSize  actual target (branch_addr from execute).
- mispredict  output  1  table prediction for upd_pc disagrees with the resolution.

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rstn); all state is cleared immediately on rstn low, independent of clk.
- Index and tag:
  - IdxBits = log2(Entries); OffBits = log2(InstBytes).
  - idx = pc[OffBits+IdxBits-1:OffBits].
  - tag = pc[WordSize-1:OffBits+IdxBits].
- Per entry: valid (1b), tag, target (WordSize), ctr (2b).
- Reset values: valid = 0 for all entries; ctr = 2'b01 (weakly not-taken); tag and target = 0.
- Outputs during and after reset (all entries invalid):
  - pred_taken = 0, pred_target = 0, pred_npc = fetch_pc + InstBytes, mispredict = 0.
- Lookup (combinational, zero latency) on fetch_pc:
  - hit = valid[idx] and tag match.
  - pred_taken = hit and ctr[idx][1].
  - pred_target = hit ? target[idx] : 0.
  - pred_npc = pred_taken ? target[idx] : fetch_pc + InstBytes, wrapping modulo 2^WordSize.
- mispredict (combinational): the same lookup is performed on upd_pc, giving p_taken and p_target.
  - mispredict = upd_valid and (p_taken != upd_taken, or upd_taken and p_target != upd_target).
  - mispredict = 0 when upd_valid = 0.
- Update (rising clk edge, when upd_valid = 1), using idx/tag of upd_pc:
  - Hit, taken: ctr saturating increment (max 11); target <= upd_target.
  - Hit, not taken: ctr saturating decrement (min 00); target unchanged.
  - Miss, taken: allocate. valid <= 1, tag <= new tag, target <= upd_target, ctr <= 2'b10; any conflicting entry is evicted.
  - Miss, not taken: no state change.
- Simultaneous lookup and update to the same index: lookup returns pre-update contents; no bypass. The new state is visible from the next cycle.
- upd_valid = 0: no state change.
- Reset mid-operation: an update in flight on the same edge as reset assertion is discarded.
- No stalls or handshakes: the block accepts an update every cycle.

Decomposition:
- Shared package (bp_pkg):
  - ctr_t enum: SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11.
  - Reset counter constant CTR_RESET = WNT.
  - Allocate counter constant CTR_ALLOC = WT.
  - The existing address-mode constants PC and RD move into this package alongside them.
- One sub-module, bp_sat_counter: combinational 2-bit saturating next-state function with inputs ctr_in and taken, and output ctr_out. It is instantiated once for the update path.

Test Plan:
- Reset, then fetch_pc = 0x100 → pred_taken = 0, pred_target = 0, pred_npc = 0x104, mispredict = 0.
- Update pc = 0x100, taken, target = 0x200 (mispredict = 1 that cycle); next cycle fetch 0x100 → pred_taken = 1, pred_npc = 0x200, ctr = WT.
- Two not-taken updates at 0x100 after allocation → ctr WT→WNT→SNT; fetch 0x100 → pred_npc = 0x104. Third not-taken update → ctr stays SNT and mispredict = 0.
- Saturate taken: three taken updates → ctr stays ST. A taken update with target 0x300 → mispredict = 1, and the next fetch gives pred_npc = 0x300.
- Aliasing with Entries = 16: allocate 0x100 taken, then 0x140 taken to target 0x80 → fetch 0x100 misses (pred_npc = 0x104), fetch 0x140 → pred_npc = 0x80.
- Same-cycle update and fetch at 0x100 → fetch shows old (miss) prediction, new prediction the following cycle. Wrap case: fetch 0xFFFFFFFC on miss → pred_npc = 0x0. Assert rstn mid-run → all predictions revert to fall-through immediately.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch prediction unit.
package bp_pkg;

  // 2-bit saturating direction counter states
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;
  localparam ctr_t CTR_ALLOC = WT;

  // Address-mode selectors carried over from the branch-address calculator
  localparam logic PC = 1'b0;
  localparam logic RD = 1'b1;

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state function of a 2-bit saturating direction counter.
module bp_sat_counter
  import bp_pkg::*;
(
  input  ctr_t ctr_in,
  input  logic taken,
  output ctr_t ctr_out
);

  // Step toward ST on taken, toward SNT on not-taken, holding at the ends
  always_comb begin
    ctr_out = ctr_in;
    unique case (ctr_in)
      SNT: ctr_out = taken ? WNT : SNT;
      WNT: ctr_out = taken ? WT  : SNT;
      WT:  ctr_out = taken ? ST  : WNT;
      ST:  ctr_out = taken ? ST  : WT;
      default: ctr_out = ctr_in;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency fetch lookup,
// execute-stage training and mispredict detection.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int unsigned WordSize  = 32,
  parameter int unsigned Entries   = 16,
  parameter int unsigned InstBytes = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [WordSize-1:0] fetch_pc,
  output logic                pred_taken,
  output logic [WordSize-1:0] pred_target,
  output logic [WordSize-1:0] pred_npc,
  input  logic                upd_valid,
  input  logic [WordSize-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [WordSize-1:0] upd_target,
  output logic                mispredict
);

  localparam int unsigned IdxBits = $clog2(Entries);
  localparam int unsigned OffBits = $clog2(InstBytes);
  localparam int unsigned TagBits = WordSize - OffBits - IdxBits;

  logic [Entries-1:0]  r_valid;
  logic [TagBits-1:0]  r_tag    [Entries];
  logic [WordSize-1:0] r_target [Entries];
  ctr_t                r_ctr    [Entries];

  logic [IdxBits-1:0]  w_f_idx;
  logic [TagBits-1:0]  w_f_tag;
  logic                w_f_hit;
  logic                w_f_taken;

  logic [IdxBits-1:0]  w_u_idx;
  logic [TagBits-1:0]  w_u_tag;
  logic                w_u_hit;
  logic                w_u_taken;
  logic [WordSize-1:0] w_u_target;
  ctr_t                w_u_ctr;
  ctr_t                w_ctr_next;

  assign w_f_idx = fetch_pc[OffBits +: IdxBits];
  assign w_f_tag = fetch_pc[WordSize-1 -: TagBits];
  assign w_u_idx = upd_pc[OffBits +: IdxBits];
  assign w_u_tag = upd_pc[WordSize-1 -: TagBits];

  // Byte-offset bits of the update PC never select anything
  if (OffBits > 0) begin : g_off
    logic w_unused_upd_off;
    assign w_unused_upd_off = ^upd_pc[OffBits-1:0];
  end

  // Fetch-side lookup; reads pre-update contents, no bypass
  always_comb begin
    w_f_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    w_f_taken   = w_f_hit && r_ctr[w_f_idx][1];
    pred_taken  = w_f_taken;
    pred_target = w_f_hit ? r_target[w_f_idx] : '0;
    pred_npc    = w_f_taken ? r_target[w_f_idx] : fetch_pc + WordSize'(InstBytes);
  end

  // Execute-side lookup and mispredict flag; held low while in reset
  always_comb begin
    w_u_hit    = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    w_u_ctr    = r_ctr[w_u_idx];
    w_u_taken  = w_u_hit && w_u_ctr[1];
    w_u_target = w_u_hit ? r_target[w_u_idx] : '0;
    mispredict = rstn && upd_valid &&
                 ((w_u_taken != upd_taken) || (upd_taken && (w_u_target != upd_target)));
  end

  bp_sat_counter u_ctr (
    .ctr_in  (w_u_ctr),
    .taken   (upd_taken),
    .ctr_out (w_ctr_next)
  );

  // Train on resolved branches: adjust counter on hit, allocate on taken miss
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < Entries; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_RESET;
      end
    end else if (upd_valid) begin
      if (w_u_hit) begin
        r_ctr[w_u_idx] <= w_ctr_next;
        if (upd_taken) r_target[w_u_idx] <= upd_target;
      end else if (upd_taken) begin
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= upd_target;
        r_ctr[w_u_idx]    <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (default parameters).
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] pred_npc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        mispredict;

  int checks = 0;
  int errors = 0;

  branch_predict_unit #(.WordSize(32), .Entries(16), .InstBytes(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .fetch_pc    (fetch_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .pred_npc    (pred_npc),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .mispredict  (mispredict)
  );

  always #5 clk = ~clk;

  // Apply inputs mid-cycle and let combinational outputs settle
  task automatic drive(input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt);
    fetch_pc   = fpc;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_taken  = ut;
    upd_target = utgt;
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b expected 0", pred_taken); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL reset_target got %h expected 0", pred_target); end
    checks++; if (pred_npc !== 32'h104) begin errors++; $display("FAIL reset_npc got %h expected 104", pred_npc); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict got %b expected 0", mispredict); end
    @(negedge clk);
    rstn = 1'b1;
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pred_npc !== 32'h104) begin errors++; $display("FAIL post_reset_npc got %h expected 104", pred_npc); end
  endtask

  task automatic test_allocate;
    // Update and fetch the same PC in the same cycle: fetch sees the old miss
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200);
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mispredict got %b expected 1", mispredict); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_taken got %b expected 0", pred_taken); end
    checks++; if (pred_npc !== 32'h104) begin errors++; $display("FAIL same_cycle_npc got %h expected 104", pred_npc); end
    @(negedge clk);
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_taken got %b expected 1", pred_taken); end
    checks++; if (pred_npc !== 32'h200) begin errors++; $display("FAIL alloc_npc got %h expected 200", pred_npc); end
    checks++; if (pred_target !== 32'h200) begin errors++; $display("FAIL alloc_target got %h expected 200", pred_target); end
  endtask

  task automatic test_not_taken;
    // WT -> WNT: predicted taken, resolved not-taken
    drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h0);
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL nt1_mispredict got %b expected 1", mispredict); end
    @(negedge clk);
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL wnt_taken got %b expected 0", pred_taken); end
    checks++; if (pred_target !== 32'h200) begin errors++; $display("FAIL wnt_target got %h expected 200", pred_target); end
    checks++; if (pred_npc !== 32'h104) begin errors++; $display("FAIL wnt_npc got %h expected 104", pred_npc); end
    // WNT -> SNT
    drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h0);
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL nt2_mispredict got %b expected 0", mispredict); end
    @(negedge clk);
    // SNT stays SNT
    drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h0);
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL nt3_mispredict got %b expected 0", mispredict); end
    @(negedge clk);
    // SNT -> WNT on one taken: still predicted not-taken (WNT would reach WT)
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200);
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL snt_taken_mispredict got %b expected 1", mispredict); end
    @(negedge clk);
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL snt_floor_taken got %b expected 0", pred_taken); end
  endtask

  task automatic test_saturate;
    // WNT -> WT
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200);
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL sat1_mispredict got %b expected 1", mispredict); end
    @(negedge clk);
    // WT -> ST -> ST -> ST
    for (int i = 0; i < 3; i++) begin
      drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200);
      checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL sat_mispredict[%0d] got %b expected 0", i, mispredict); end
      @(negedge clk);
    end
    // ST -> WT: one not-taken must leave it predicting taken
    drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h0);
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL st_nt_mispredict got %b expected 1", mispredict); end
    @(negedge clk);
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL st_ceiling_taken got %b expected 1", pred_taken); end
    // Target change on a taken hit
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h300);
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL retarget_mispredict got %b expected 1", mispredict); end
    checks++; if (pred_npc !== 32'h200) begin errors++; $display("FAIL retarget_old_npc got %h expected 200", pred_npc); end
    @(negedge clk);
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pred_npc !== 32'h300) begin errors++; $display("FAIL retarget_npc got %h expected 300", pred_npc); end
  endtask

  task automatic test_alias;
    // 0x140 maps to the same index as 0x100 with a different tag
    drive(32'h140, 1'b1, 32'h140, 1'b1, 32'h80);
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL alias_mispredict got %b expected 1", mispredict); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_pre_taken got %b expected 0", pred_taken); end
    @(negedge clk);
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pred_npc !== 32'h104) begin errors++; $display("FAIL evicted_npc got %h expected 104", pred_npc); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL evicted_target got %h expected 0", pred_target); end
    drive(32'h140, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pred_npc !== 32'h80) begin errors++; $display("FAIL alias_npc got %h expected 80", pred_npc); end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    drive(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pred_npc !== 32'h0) begin errors++; $display("FAIL wrap_npc got %h expected 0", pred_npc); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL wrap_taken got %b expected 0", pred_taken); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    drive(32'h104, 1'b1, 32'h104, 1'b1, 32'h400);
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL b2b_a_mispredict got %b expected 1", mispredict); end
    @(negedge clk);
    drive(32'h104, 1'b1, 32'h108, 1'b1, 32'h500);
    checks++; if (pred_npc !== 32'h400) begin errors++; $display("FAIL b2b_a_npc got %h expected 400", pred_npc); end
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL b2b_b_mispredict got %b expected 1", mispredict); end
    @(negedge clk);
    drive(32'h108, 1'b1, 32'h104, 1'b1, 32'h400);
    checks++; if (pred_npc !== 32'h500) begin errors++; $display("FAIL b2b_b_npc got %h expected 500", pred_npc); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL b2b_c_mispredict got %b expected 0", mispredict); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    // Reset asserted mid-cycle with an update pending on 0x10C
    drive(32'h104, 1'b1, 32'h10C, 1'b1, 32'h600);
    checks++; if (pred_npc !== 32'h400) begin errors++; $display("FAIL pre_rst_npc got %h expected 400", pred_npc); end
    rstn = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL mid_rst_taken got %b expected 0", pred_taken); end
    checks++; if (pred_npc !== 32'h108) begin errors++; $display("FAIL mid_rst_npc got %h expected 108", pred_npc); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL mid_rst_target got %h expected 0", pred_target); end
    @(negedge clk);
    rstn = 1'b1;
    drive(32'h10C, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL discarded_upd_target got %h expected 0", pred_target); end
    checks++; if (pred_npc !== 32'h110) begin errors++; $display("FAIL discarded_upd_npc got %h expected 110", pred_npc); end
    drive(32'h140, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pred_npc !== 32'h144) begin errors++; $display("FAIL cleared_npc got %h expected 144", pred_npc); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_not_taken();
    test_saturate();
    test_alias();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
